fft_job_sequencer: RTL
======================

# fft_job_sequencer

Job-level controller for the FFT engine. Accepts a start command with a point configuration and sequences each job through sample load, datapath run, and result unload. It owns the datapath's working strobe, cycle budget and active-low datapath reset. It also arbitrates the shared sample SRAM port between the host load/unload streams and the engine.

## Interface
- PIPE_DELAY, 10: datapath write-back latency in cycles; used in the cycle-budget formula.
- clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  job request; sampled only in IDLE.
- i_abort  in  1  abandon the current job; honoured in any non-IDLE state.
- i_point_configuration  in  3  cfg; N = 8<<cfg points (8..1024); latched on accepted start.
- i_in_valid  in  1  host sample-load beat valid.
- o_in_ready  out  1  ready for a load beat; high in LOAD only.
- o_sram_addr  out  10  shared SRAM port address; host-side phases only.
- o_sram_we  out  1  SRAM write strobe = i_in_valid & o_in_ready.
- o_sram_re  out  1  SRAM read strobe during UNLOAD.
- o_out_valid  out  1  SRAM read data on the bus is a valid result beat.
- i_out_ready  in  1  host accepts result beat.
- o_dp_resetn  out  1  active-low reset to datapath/point-config logic.
- o_working  out  1  datapath run enable.
- o_point_configuration  out  3  latched cfg to the datapath.
- o_cycle_count  out  11  cycle budget to the datapath.
- i_fft_done  in  1  level from the datapath: computation finished.
- i_result_bank  in  1  datapath's current SRAM read-bank select.
- o_result_bank  out  1  bank holding results; latched on i_fft_done rise.
- o_busy  out  1  state != IDLE.
- o_job_done  out  1  one-cycle pulse after the last result beat is accepted.

## Operation
- States: IDLE, CLEAR, LOAD, RUN, UNLOAD, DONE.
- IDLE -> CLEAR on i_start; latch cfg; compute N.
- CLEAR lasts exactly 1 cycle with o_dp_resetn=0, then -> LOAD.
- LOAD: o_in_ready=1; an address counter (0..N-1) drives o_sram_addr and increments on each we beat.
  - Leave to RUN on the beat writing address N-1.
- RUN: o_working=1; SRAM port is owned by the engine (o_sram_addr=0, we/re=0).
  - On the first cycle with i_fft_done=1: latch o_result_bank<=i_result_bank, clear the counter, -> UNLOAD.
- UNLOAD: issue a read (o_sram_re=1, o_sram_addr=counter) when reads remain and (!o_out_valid | i_out_ready).
  - Counter increments per issued read.
  - o_out_valid is set the cycle after a read is issued. It is cleared on i_out_ready when no new read is issued, and holds otherwise.
  - -> DONE when the beat for address N-1 is accepted.
- DONE: o_job_done=1 for 1 cycle -> IDLE.
- Abort: in any non-IDLE state, i_abort forces the next state to CLEAR, then IDLE (not LOAD). Counters and o_out_valid clear; o_job_done is not pulsed. i_abort has priority over every other transition.
- Cycle budget: o_cycle_count = (cfg+3) * ((N>>3) + PIPE_DELAY + 1), computed combinationally from the latched cfg.
  - Must be 11 bits wide, saturating at 2047. cfg=7 with PIPE_DELAY=10 gives 1390, so no saturation.
- o_point_configuration holds the latched cfg from start until the next accepted start; it does not change mid-job.

## Timing
- Reset values: state=IDLE, o_dp_resetn=0 while i_reset is high, then 1.
  - o_in_ready, o_sram_we, o_sram_re, o_out_valid, o_working, o_busy, o_job_done, o_result_bank = 0.
  - o_sram_addr=0, o_point_configuration=0, o_cycle_count=(0+3)*(1+PIPE_DELAY+1)=36.
- Start latency: i_start at cycle t gives CLEAR at t+1 (o_dp_resetn=0) and o_in_ready=1 at t+2.
- i_start is ignored while o_busy. i_start together with i_abort in IDLE: start wins.
- RUN is entered the cycle after the last load beat; o_working is registered high from that cycle.
- i_fft_done already high on RUN entry: the transition still occurs that cycle (minimum RUN length 1).
- SRAM read latency is 1 cycle; data is aligned to o_out_valid. At most one outstanding read, so throughput is 1 beat/cycle under continuous ready.
- Reset asserted mid-job returns to IDLE immediately with all outputs at reset values.

## Test plan
- cfg=0, continuous valid/ready: 8 load beats at addresses 0..7; RUN with o_cycle_count=36.
  - i_fft_done after 20 cycles gives 8 result beats on consecutive cycles, then one o_job_done pulse. Total busy = 1+8+20+1+8+1 cycles ±1.
- cfg=7: 1024 load beats with random i_in_valid gaps; addresses stay contiguous and o_sram_we count = 1024; o_cycle_count=1390.
- Unload backpressure: i_out_ready toggles randomly; no beat is dropped or duplicated, o_out_valid holds while ready is low, and at most one read is outstanding.
- Abort in LOAD (beat 3), in RUN, and in UNLOAD: each gives exactly one o_dp_resetn=0 cycle, then IDLE with o_job_done=0. A subsequent job completes normally.
- i_result_bank=1 when i_fft_done rises gives o_result_bank=1 for all of UNLOAD. i_start during busy has no effect.
- Async i_reset pulse mid-RUN: all outputs reach reset values without waiting for a clock edge; the next start behaves normally.

Source files
------------

// File: rtl/fft_job_sequencer.sv
// Job-level sequencer for the FFT engine: start -> clear -> sample load -> run -> result unload.
// Owns the datapath reset, run strobe and cycle budget, and the host side of the shared sample SRAM port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for i_start
// S_CLEAR  | one-cycle datapath reset; goes to LOAD, or IDLE after abort
// S_LOAD   | host writes N samples into SRAM
// S_RUN    | engine owns SRAM, waits for i_fft_done
// S_UNLOAD | host reads N results, one read outstanding at most
// S_DONE   | one-cycle job-done pulse
module fft_job_sequencer #(
    parameter int PIPE_DELAY = 10
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [2:0]  i_point_configuration,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [9:0]  o_sram_addr,
    output logic        o_sram_we,
    output logic        o_sram_re,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_dp_resetn,
    output logic        o_working,
    output logic [2:0]  o_point_configuration,
    output logic [10:0] o_cycle_count,
    input  logic        i_fft_done,
    input  logic        i_result_bank,
    output logic        o_result_bank,
    output logic        o_busy,
    output logic        o_job_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [2:0]  cfg_q;
    logic [10:0] cnt;
    logic [10:0] n_points;
    logic        abort_clear;
    logic        out_valid;
    logic        result_bank;
    logic        load_beat;
    logic        rd_issue;
    logic        beat_accept;
    logic        abort_hit;
    logic [31:0] budget_full;

    assign n_points    = 11'd8 << cfg_q;
    assign abort_hit   = (state != S_IDLE) && i_abort;
    assign load_beat   = (state == S_LOAD) && i_in_valid;
    assign rd_issue    = (state == S_UNLOAD) && (cnt < n_points) && (!out_valid || i_out_ready);
    assign beat_accept = out_valid && i_out_ready;

    // Budget = (cfg+3) * (N/8 + PIPE_DELAY + 1), clamped to the 11-bit range
    always_comb begin
        budget_full   = (32'(cfg_q) + 32'd3) * (32'(n_points >> 3) + 32'(PIPE_DELAY) + 32'd1);
        o_cycle_count = (budget_full > 32'd2047) ? 11'd2047 : budget_full[10:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (i_start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = abort_clear ? S_IDLE : S_LOAD;
            S_LOAD:   if (load_beat && (cnt == n_points - 11'd1)) state_nxt = S_RUN;
            S_RUN:    if (i_fft_done) state_nxt = S_UNLOAD;
            S_UNLOAD: if (beat_accept && (cnt == n_points)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_CLEAR;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cfg_q       <= 3'd0;
            cnt         <= 11'd0;
            abort_clear <= 1'b0;
            out_valid   <= 1'b0;
            result_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (abort_hit) begin
                abort_clear <= 1'b1;
                cnt         <= 11'd0;
                out_valid   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            cfg_q       <= i_point_configuration;
                            abort_clear <= 1'b0;
                            cnt         <= 11'd0;
                        end
                    end
                    S_CLEAR: begin
                        abort_clear <= 1'b0;
                        cnt         <= 11'd0;
                    end
                    S_LOAD: begin
                        if (load_beat) cnt <= cnt + 11'd1;
                    end
                    S_RUN: begin
                        if (i_fft_done) begin
                            result_bank <= i_result_bank;
                            cnt         <= 11'd0;
                        end
                    end
                    S_UNLOAD: begin
                        // A new read keeps valid high; otherwise the pending beat retires on ready
                        if (rd_issue) begin
                            cnt       <= cnt + 11'd1;
                            out_valid <= 1'b1;
                        end else if (i_out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_in_ready            = (state == S_LOAD);
    assign o_sram_we             = load_beat;
    assign o_sram_re             = rd_issue;
    assign o_sram_addr           = ((state == S_LOAD) || (state == S_UNLOAD)) ? cnt[9:0] : 10'd0;
    assign o_out_valid           = out_valid;
    assign o_dp_resetn           = !i_reset && (state != S_CLEAR);
    assign o_working             = (state == S_RUN);
    assign o_point_configuration = cfg_q;
    assign o_result_bank         = result_bank;
    assign o_busy                = (state != S_IDLE);
    assign o_job_done            = (state == S_DONE);

endmodule
